// File: rtl/object_fetcher_if.sv
// Object types shared by the fetcher and its neighbours, plus the bundle that
// groups the object-buffer read side and the downstream valid/ready side.
package object_fetcher_pkg;
  localparam int unsigned COORD_W = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } vertex_t;

  typedef struct packed {
    vertex_t a;
    vertex_t b;
    vertex_t c;
  } object_t;
endpackage

interface object_fetcher_if #(
  parameter int unsigned MAX_OBJECTS = 50
);
  localparam int unsigned IDX_W = $clog2(MAX_OBJECTS) + 1;

  // object buffer side
  logic                        switch_buffer;
  logic                        read_b;
  object_fetcher_pkg::object_t data_b;
  logic                        read_end;

  // downstream side
  object_fetcher_pkg::object_t obj_out;
  object_fetcher_pkg::coord_t  bbox_min_x;
  object_fetcher_pkg::coord_t  bbox_min_y;
  object_fetcher_pkg::coord_t  bbox_max_x;
  object_fetcher_pkg::coord_t  bbox_max_y;
  logic                        obj_valid;
  logic                        obj_ready;
  logic [IDX_W-1:0]            obj_index;

  modport master (
    output switch_buffer, read_b,
    input  data_b, read_end,
    output obj_out, bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y,
    output obj_valid, obj_index,
    input  obj_ready
  );

  modport slave (
    input  switch_buffer, read_b,
    output data_b, read_end,
    input  obj_out, bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y,
    input  obj_valid, obj_index,
    output obj_ready
  );
endinterface

// File: rtl/object_fetcher.sv
// Walks the object buffer once per start request, presenting each object with
// its bounding box downstream over a valid/ready handshake.
module object_fetcher
  import object_fetcher_pkg::*;
#(
  parameter int unsigned MAX_OBJECTS = 50
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  object_fetcher_if.master  bus
);
  localparam int unsigned IDX_W = $clog2(MAX_OBJECTS) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REWIND  = 3'd1,
    CAPTURE = 3'd2,
    PRESENT = 3'd3,
    ADVANCE = 3'd4,
    GAP     = 3'd5,
    FINISH  = 3'd6
  } state_t;

  state_t state;
  state_t state_next;
  logic   last;

  logic busy_d;
  logic done_d;
  logic switch_d;
  logic read_d;
  logic valid_d;

  function automatic coord_t min3(input coord_t p, input coord_t q, input coord_t r);
    coord_t m;
    m = p;
    if (q < m) m = q;
    if (r < m) m = r;
    return m;
  endfunction

  function automatic coord_t max3(input coord_t p, input coord_t q, input coord_t r);
    coord_t m;
    m = p;
    if (q > m) m = q;
    if (r > m) m = r;
    return m;
  endfunction

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = REWIND;
      REWIND:  state_next = CAPTURE;
      CAPTURE: state_next = PRESENT;
      PRESENT: if (bus.obj_ready) state_next = last ? FINISH : ADVANCE;
      ADVANCE: state_next = GAP;
      GAP:     state_next = CAPTURE;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flops below track the state exactly
  always_comb begin
    busy_d   = (state_next != IDLE);
    done_d   = (state_next == FINISH);
    switch_d = (state_next == REWIND);
    read_d   = (state_next == ADVANCE);
    valid_d  = (state_next == PRESENT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy              <= 1'b0;
      done              <= 1'b0;
      bus.switch_buffer <= 1'b0;
      bus.read_b        <= 1'b0;
      bus.obj_valid     <= 1'b0;
    end else begin
      busy              <= busy_d;
      done              <= done_d;
      bus.switch_buffer <= switch_d;
      bus.read_b        <= read_d;
      bus.obj_valid     <= valid_d;
    end
  end

  // Object capture, bounding box and pass position
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.obj_out    <= '0;
      bus.bbox_min_x <= '0;
      bus.bbox_min_y <= '0;
      bus.bbox_max_x <= '0;
      bus.bbox_max_y <= '0;
      bus.obj_index  <= '0;
      last           <= 1'b0;
    end else begin
      if (state_next == REWIND)       bus.obj_index <= '0;
      else if (state_next == ADVANCE) bus.obj_index <= bus.obj_index + IDX_W'(1);

      if (state == CAPTURE) begin
        bus.obj_out    <= bus.data_b;
        bus.bbox_min_x <= min3(bus.data_b.a.x, bus.data_b.b.x, bus.data_b.c.x);
        bus.bbox_min_y <= min3(bus.data_b.a.y, bus.data_b.b.y, bus.data_b.c.y);
        bus.bbox_max_x <= max3(bus.data_b.a.x, bus.data_b.b.x, bus.data_b.c.x);
        bus.bbox_max_y <= max3(bus.data_b.a.y, bus.data_b.b.y, bus.data_b.c.y);
        // The index guard stops a pass even if the buffer never flags its end
        last <= bus.read_end || (bus.obj_index == IDX_W'(MAX_OBJECTS - 1));
      end
    end
  end

endmodule

// File: tb/tb_object_fetcher.sv
// Directed bench for object_fetcher: a cycle table for the basic two-object
// pass, then hand sequences for stalls, reset, single-object and guard passes.
module tb_object_fetcher;
  import object_fetcher_pkg::*;

  localparam int unsigned MAXO = 50;
  localparam logic [63:0] BB0 = {16'd10, 16'd10, 16'd100, 16'd75};
  localparam logic [63:0] BB1 = {16'd500, 16'd100, 16'd600, 16'd300};

  logic clock = 1'b0;
  logic reset;
  logic start0;
  logic start4;
  logic busy0, done0, busy4, done4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  object_fetcher_if #(.MAX_OBJECTS(MAXO)) bus0 ();
  object_fetcher_if #(.MAX_OBJECTS(4))    bus4 ();

  object_fetcher #(.MAX_OBJECTS(MAXO)) dut (
    .clock(clock), .reset(reset), .start(start0),
    .busy(busy0), .done(done0), .bus(bus0.master)
  );

  object_fetcher #(.MAX_OBJECTS(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4),
    .busy(busy4), .done(done4), .bus(bus4.master)
  );

  function automatic object_t mk(input int ax, input int ay, input int bx,
                                 input int by, input int cx, input int cy);
    object_t o;
    o.a.x = 16'(ax); o.a.y = 16'(ay);
    o.b.x = 16'(bx); o.b.y = 16'(by);
    o.c.x = 16'(cx); o.c.y = 16'(cy);
    return o;
  endfunction

  function automatic object_t mk4(input int i);
    return mk(i, i + 1, i + 2, i, i, i + 3);
  endfunction

  // Object buffer models: rewind on switch_buffer, advance on a read_b rising edge
  object_t    buf0 [4];
  int         cnt0 = 2;
  logic [1:0] cur0 = '0;
  logic       rb0_q = 1'b0;
  logic [3:0] cur4 = '0;
  logic       rb4_q = 1'b0;

  always @(posedge clock) begin
    rb0_q <= bus0.read_b;
    if (bus0.switch_buffer) cur0 <= '0;
    else if (bus0.read_b && !rb0_q && cur0 != 2'd3) cur0 <= cur0 + 2'd1;
    rb4_q <= bus4.read_b;
    if (bus4.switch_buffer) cur4 <= '0;
    else if (bus4.read_b && !rb4_q) cur4 <= cur4 + 4'd1;
  end

  assign bus0.data_b   = buf0[cur0];
  assign bus0.read_end = (int'(cur0) == cnt0 - 1);
  assign bus4.data_b   = mk4(int'(cur4));
  assign bus4.read_end = 1'b0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] ctrl0();
    return {busy0, done0, bus0.switch_buffer, bus0.read_b, bus0.obj_valid};
  endfunction

  function automatic logic [4:0] ctrl4();
    return {busy4, done4, bus4.switch_buffer, bus4.read_b, bus4.obj_valid};
  endfunction

  function automatic logic [63:0] bbox0();
    return {bus0.bbox_min_x, bus0.bbox_min_y, bus0.bbox_max_x, bus0.bbox_max_y};
  endfunction

  // One full pass with obj_ready high: counts beats, read pulses and done
  task automatic run_pass(input bit sel4, input bit hold_start, input int exp_beats,
                          input int exp_reads, input string nm);
    int   beats = 0;
    int   reads = 0;
    bit   seen  = 0;
    bit   prev_rd = 0;
    logic [4:0] c;
    int   idx;
    object_t o;
    bus0.obj_ready = 1'b1;
    bus4.obj_ready = 1'b1;
    if (sel4) start4 = 1'b1; else start0 = 1'b1;
    step();
    if (sel4) start4 = hold_start; else start0 = hold_start;
    c = sel4 ? ctrl4() : ctrl0();
    chk({nm, " rewind"}, 96'(c), 96'(5'b10100));
    for (int k = 0; k < 400 && !seen; k++) begin
      step();
      c   = sel4 ? ctrl4() : ctrl0();
      idx = sel4 ? int'(bus4.obj_index) : int'(bus0.obj_index);
      o   = sel4 ? bus4.obj_out : bus0.obj_out;
      if (prev_rd) chk({nm, " gap"}, 96'(c[1]), 96'(0));
      if (c[1]) reads++;
      if (c[0]) begin
        chk($sformatf("%s idx%0d", nm, beats), 96'(idx), 96'(beats));
        if (sel4) chk($sformatf("%s obj%0d", nm, beats), 96'(o), 96'(mk4(beats)));
        beats++;
      end
      if (c[3]) seen = 1;
      prev_rd = c[1];
    end
    chk({nm, " done seen"}, 96'(seen), 96'(1));
    chk({nm, " beats"}, 96'(beats), 96'(exp_beats));
    chk({nm, " reads"}, 96'(reads), 96'(exp_reads));
    if (sel4) start4 = 1'b0; else start0 = 1'b0;
    step();
    c = sel4 ? ctrl4() : ctrl0();
    chk({nm, " idle after"}, 96'(c), 96'(0));
  endtask

  typedef struct {
    logic       start;
    logic       ready;
    logic [4:0] ctrl;   // {busy, done, switch_buffer, read_b, obj_valid}
    int         idx;
    logic [63:0] bbox;
  } vec_t;

  vec_t vt [10];

  initial begin
    bit seen;
    reset = 1'b1;
    start0 = 1'b0;
    start4 = 1'b0;
    bus0.obj_ready = 1'b1;
    bus4.obj_ready = 1'b1;
    buf0[0] = mk(10, 10, 100, 15, 50, 75);
    buf0[1] = mk(500, 100, 600, 100, 600, 300);
    buf0[2] = '0;
    buf0[3] = '0;

    vt[0] = '{1'b1, 1'b1, 5'b10100, 0, 64'h0};  // REWIND
    vt[1] = '{1'b0, 1'b1, 5'b10000, 0, 64'h0};  // CAPTURE
    vt[2] = '{1'b0, 1'b1, 5'b10001, 0, BB0};    // PRESENT beat 0
    vt[3] = '{1'b0, 1'b1, 5'b10010, 1, BB0};    // ADVANCE
    vt[4] = '{1'b0, 1'b1, 5'b10000, 1, BB0};    // GAP
    vt[5] = '{1'b0, 1'b1, 5'b10000, 1, BB0};    // CAPTURE
    vt[6] = '{1'b0, 1'b1, 5'b10001, 1, BB1};    // PRESENT beat 1
    vt[7] = '{1'b0, 1'b1, 5'b11000, 1, BB1};    // FINISH
    vt[8] = '{1'b0, 1'b1, 5'b00000, 1, BB1};    // IDLE
    vt[9] = '{1'b0, 1'b1, 5'b00000, 1, BB1};    // stays IDLE

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset ctrl", 96'(ctrl0()), 96'(0));
    chk("reset idx", 96'(bus0.obj_index), 96'(0));
    chk("reset bbox", 96'(bbox0()), 96'(0));
    chk("reset obj", 96'(bus0.obj_out), 96'(0));
    chk("reset ctrl4", 96'(ctrl4()), 96'(0));

    // Two-object pass, cycle by cycle
    for (int i = 0; i < 10; i++) begin
      start0 = vt[i].start;
      bus0.obj_ready = vt[i].ready;
      step();
      chk($sformatf("vec%0d ctrl", i), 96'(ctrl0()), 96'(vt[i].ctrl));
      chk($sformatf("vec%0d idx", i), 96'(bus0.obj_index), 96'(vt[i].idx));
      chk($sformatf("vec%0d bbox", i), 96'(bbox0()), 96'(vt[i].bbox));
    end

    // Downstream stall on beat 0
    bus0.obj_ready = 1'b0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d ctrl", k), 96'(ctrl0()), 96'(5'b10001));
      chk($sformatf("stall%0d obj", k), 96'(bus0.obj_out), 96'(buf0[0]));
      if (k < 4) step();
    end
    bus0.obj_ready = 1'b1;
    step();
    chk("stall accept", 96'(ctrl0()), 96'(5'b10010));
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (done0) seen = 1;
    end
    chk("stall done", 96'(seen), 96'(1));
    step();

    // start held high for the whole pass must not disturb it
    run_pass(1'b0, 1'b1, 2, 1, "busy_start");

    // Asynchronous reset in the middle of ADVANCE
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    step();
    step();
    chk("pre-reset advance", 96'(ctrl0()), 96'(5'b10010));
    #2 reset = 1'b1;
    #1;
    chk("midreset ctrl", 96'(ctrl0()), 96'(0));
    chk("midreset idx", 96'(bus0.obj_index), 96'(0));
    chk("midreset bbox", 96'(bbox0()), 96'(0));
    chk("midreset obj", 96'(bus0.obj_out), 96'(0));
    @(negedge clock);
    reset = 1'b0;
    step();
    chk("post-reset idle", 96'(ctrl0()), 96'(0));
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("restart rewind", 96'(ctrl0()), 96'(5'b10100));
    step();
    step();
    chk("restart beat0 bbox", 96'(bbox0()), 96'(BB0));
    chk("restart beat0 obj", 96'(bus0.obj_out), 96'(buf0[0]));
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (done0) seen = 1;
    end
    chk("restart done", 96'(seen), 96'(1));
    step();

    // Single degenerate object: read_end high at first capture
    cnt0 = 1;
    buf0[0] = mk(7, 7, 7, 7, 7, 20);
    run_pass(1'b0, 1'b0, 1, 0, "single");
    chk("single bbox", 96'(bbox0()), 96'({16'd7, 16'd7, 16'd7, 16'd20}));

    // MAX_OBJECTS guard with read_end never asserted
    run_pass(1'b1, 1'b0, 4, 3, "guard");
    chk("guard last idx", 96'(bus4.obj_index), 96'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
